id_ex_stage: RTL and testbench

ID/EX pipeline stage of the MIPS pipeline. Captures the decode-stage control word produced by the main control unit, together with register operands, the sign-extended immediate and the register specifiers, and presents them to EX one cycle later. Contains the load-use hazard detector. The detector stalls PC and IF/ID and injects a bubble into ID/EX. The stage also honours a branch flush and a global hold.

---
 rtl/mips_pipe_pkg.sv | 30 +++
 rtl/load_use_detect.sv | 23 ++
 rtl/id_ex_stage.sv | 121 ++++++++++++
 tb/tb_id_ex_stage.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared MIPS pipeline types: ALU op codes, register-specifier constants
// and the packed decode control word carried from ID into EX.
package mips_pipe_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] REG_ZERO = '0;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_DEF = 3'b111;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       reg_dst;
        logic       branch_ctrl;
        logic       mem_read;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic       bne;
        logic       bgtz;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector.
// In: ex_valid, ex_mem_read, ex_rt, id_valid, id_rs, id_rt. Out: load_use_stall.
module load_use_detect
    import mips_pipe_pkg::*;
(
    input  logic             ex_valid,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    output logic             load_use_stall
);

    logic rt_hit;

    // A load into $zero produces nothing a consumer could wait on.
    assign rt_hit = (ex_rt != REG_ZERO) &
                    ((ex_rt == id_rs) | (ex_rt == id_rt));

    assign load_use_stall = ex_valid & ex_mem_read & id_valid & rt_hit;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, branch flush and hold.
// In: rst/hold/flush, id_* control+data. Out: ex_*, ex_valid, stall, PC/IFID enables.
module id_ex_stage
    import mips_pipe_pkg::*;
#(
    parameter int RF_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [2:0]       id_alu_op,
    input  logic             id_reg_dst,
    input  logic             id_branch_ctrl,
    input  logic             id_mem_read,
    input  logic             id_mem_to_reg,
    input  logic             id_mem_write,
    input  logic             id_alu_src,
    input  logic             id_reg_write,
    input  logic             id_bne,
    input  logic             id_bgtz,
    input  logic [RF_W-1:0]  id_pc4,
    input  logic [RF_W-1:0]  id_rs_data,
    input  logic [RF_W-1:0]  id_rt_data,
    input  logic [RF_W-1:0]  id_imm,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] id_rd,
    output logic             ex_valid,
    output logic [2:0]       ex_alu_op,
    output logic             ex_reg_dst,
    output logic             ex_branch_ctrl,
    output logic             ex_mem_read,
    output logic             ex_mem_to_reg,
    output logic             ex_mem_write,
    output logic             ex_alu_src,
    output logic             ex_reg_write,
    output logic             ex_bne,
    output logic             ex_bgtz,
    output logic [RF_W-1:0]  ex_pc4,
    output logic [RF_W-1:0]  ex_rs_data,
    output logic [RF_W-1:0]  ex_rt_data,
    output logic [RF_W-1:0]  ex_imm,
    output logic [REG_W-1:0] ex_rs,
    output logic [REG_W-1:0] ex_rt,
    output logic [REG_W-1:0] ex_rd,
    output logic             load_use_stall,
    output logic             pc_write_en,
    output logic             ifid_write_en
);

    ctrl_t id_ctrl;
    ctrl_t ex_ctrl;

    always_comb begin
        id_ctrl             = CTRL_BUBBLE;
        id_ctrl.alu_op      = id_alu_op;
        id_ctrl.reg_dst     = id_reg_dst;
        id_ctrl.branch_ctrl = id_branch_ctrl;
        id_ctrl.mem_read    = id_mem_read;
        id_ctrl.mem_to_reg  = id_mem_to_reg;
        id_ctrl.mem_write   = id_mem_write;
        id_ctrl.alu_src     = id_alu_src;
        id_ctrl.reg_write   = id_reg_write;
        id_ctrl.bne         = id_bne;
        id_ctrl.bgtz        = id_bgtz;
    end

    // Uses only registered EX state, so no loop back through id_*.
    load_use_detect u_lud (
        .ex_valid       (ex_valid),
        .ex_mem_read    (ex_ctrl.mem_read),
        .ex_rt          (ex_rt),
        .id_valid       (id_valid),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .load_use_stall (load_use_stall)
    );

    assign pc_write_en   = ~(hold | load_use_stall);
    assign ifid_write_en = ~(hold | load_use_stall);

    // Reset and bubble both zero the bank; hold freezes it outright,
    // so a pending stall is only acted on once hold drops.
    always_ff @(posedge clk) begin
        if (rst || (!hold && (flush || load_use_stall))) begin
            ex_valid   <= 1'b0;
            ex_ctrl    <= CTRL_BUBBLE;
            ex_pc4     <= '0;
            ex_rs_data <= '0;
            ex_rt_data <= '0;
            ex_imm     <= '0;
            ex_rs      <= '0;
            ex_rt      <= '0;
            ex_rd      <= '0;
        end else if (!hold) begin
            ex_valid   <= id_valid;
            ex_ctrl    <= id_ctrl;
            ex_pc4     <= id_pc4;
            ex_rs_data <= id_rs_data;
            ex_rt_data <= id_rt_data;
            ex_imm     <= id_imm;
            ex_rs      <= id_rs;
            ex_rt      <= id_rt;
            ex_rd      <= id_rd;
        end
    end

    assign ex_alu_op      = ex_ctrl.alu_op;
    assign ex_reg_dst     = ex_ctrl.reg_dst;
    assign ex_branch_ctrl = ex_ctrl.branch_ctrl;
    assign ex_mem_read    = ex_ctrl.mem_read;
    assign ex_mem_to_reg  = ex_ctrl.mem_to_reg;
    assign ex_mem_write   = ex_ctrl.mem_write;
    assign ex_alu_src     = ex_ctrl.alu_src;
    assign ex_reg_write   = ex_ctrl.reg_write;
    assign ex_bne         = ex_ctrl.bne;
    assign ex_bgtz        = ex_ctrl.bgtz;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed hazard scenarios
// followed by randomized traffic against a behavioural model.
module tb_id_ex_stage;

    typedef struct packed {
        logic        valid;
        logic [2:0]  alu_op;
        logic        reg_dst;
        logic        branch_ctrl;
        logic        mem_read;
        logic        mem_to_reg;
        logic        mem_write;
        logic        alu_src;
        logic        reg_write;
        logic        bne;
        logic        bgtz;
        logic [31:0] pc4;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } ins_t;

    logic clk = 1'b0;
    logic rst, hold, flush;
    ins_t cur;
    ins_t obs;
    ins_t mdl;
    logic mdl_known;
    int   n_chk, n_pass;

    logic       ex_valid, ex_reg_dst, ex_branch_ctrl, ex_mem_read;
    logic       ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_reg_write;
    logic       ex_bne, ex_bgtz;
    logic [2:0] ex_alu_op;
    logic [31:0] ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
    logic [4:0] ex_rs, ex_rt, ex_rd;
    logic       load_use_stall, pc_write_en, ifid_write_en;

    always #5 clk = ~clk;

    id_ex_stage #(.RF_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .hold           (hold),
        .flush          (flush),
        .id_valid       (cur.valid),
        .id_alu_op      (cur.alu_op),
        .id_reg_dst     (cur.reg_dst),
        .id_branch_ctrl (cur.branch_ctrl),
        .id_mem_read    (cur.mem_read),
        .id_mem_to_reg  (cur.mem_to_reg),
        .id_mem_write   (cur.mem_write),
        .id_alu_src     (cur.alu_src),
        .id_reg_write   (cur.reg_write),
        .id_bne         (cur.bne),
        .id_bgtz        (cur.bgtz),
        .id_pc4         (cur.pc4),
        .id_rs_data     (cur.rs_data),
        .id_rt_data     (cur.rt_data),
        .id_imm         (cur.imm),
        .id_rs          (cur.rs),
        .id_rt          (cur.rt),
        .id_rd          (cur.rd),
        .ex_valid       (ex_valid),
        .ex_alu_op      (ex_alu_op),
        .ex_reg_dst     (ex_reg_dst),
        .ex_branch_ctrl (ex_branch_ctrl),
        .ex_mem_read    (ex_mem_read),
        .ex_mem_to_reg  (ex_mem_to_reg),
        .ex_mem_write   (ex_mem_write),
        .ex_alu_src     (ex_alu_src),
        .ex_reg_write   (ex_reg_write),
        .ex_bne         (ex_bne),
        .ex_bgtz        (ex_bgtz),
        .ex_pc4         (ex_pc4),
        .ex_rs_data     (ex_rs_data),
        .ex_rt_data     (ex_rt_data),
        .ex_imm         (ex_imm),
        .ex_rs          (ex_rs),
        .ex_rt          (ex_rt),
        .ex_rd          (ex_rd),
        .load_use_stall (load_use_stall),
        .pc_write_en    (pc_write_en),
        .ifid_write_en  (ifid_write_en)
    );

    always_comb begin
        obs             = '0;
        obs.valid       = ex_valid;
        obs.alu_op      = ex_alu_op;
        obs.reg_dst     = ex_reg_dst;
        obs.branch_ctrl = ex_branch_ctrl;
        obs.mem_read    = ex_mem_read;
        obs.mem_to_reg  = ex_mem_to_reg;
        obs.mem_write   = ex_mem_write;
        obs.alu_src     = ex_alu_src;
        obs.reg_write   = ex_reg_write;
        obs.bne         = ex_bne;
        obs.bgtz        = ex_bgtz;
        obs.pc4         = ex_pc4;
        obs.rs_data     = ex_rs_data;
        obs.rt_data     = ex_rt_data;
        obs.imm         = ex_imm;
        obs.rs          = ex_rs;
        obs.rt          = ex_rt;
        obs.rd          = ex_rd;
    end

    task automatic chk(input string tag, input logic [255:0] got,
                       input logic [255:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, want);
    endtask

    // One clock: inputs already applied; combinational outputs checked
    // mid-cycle, model advanced at the edge, registers checked after it.
    task automatic cycle(input logic r, input logic h, input logic f,
                         output logic st);
        logic want_st;
        rst = r; hold = h; flush = f;
        #4;
        st = load_use_stall;
        want_st = mdl.valid && mdl.mem_read && cur.valid &&
                  mdl.rt != 0 && (mdl.rt == cur.rs || mdl.rt == cur.rt);
        if (mdl_known) begin
            chk("stall", load_use_stall, want_st);
            chk("pc_we", pc_write_en, !(h || want_st));
            chk("ifid_we", ifid_write_en, !(h || want_st));
        end
        @(posedge clk);
        if (r) begin
            mdl = '0;
            mdl_known = 1'b1;
        end else if (h) begin
            mdl = mdl;
        end else if (f || want_st) begin
            mdl = '0;
        end else begin
            mdl = cur;
        end
        #1;
        if (mdl_known) chk("ex_bundle", obs, mdl);
    endtask

    function automatic ins_t mk(input logic v, input logic [2:0] op,
                                input logic ld, input logic wr,
                                input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] rd);
        ins_t i;
        i = '0;
        i.valid      = v;
        i.alu_op     = op;
        i.mem_read   = ld;
        i.mem_to_reg = ld;
        i.alu_src    = ld;
        i.reg_dst    = !ld;
        i.reg_write  = wr;
        i.rs = rs; i.rt = rt; i.rd = rd;
        i.pc4     = $urandom;
        i.rs_data = $urandom;
        i.rt_data = $urandom;
        i.imm     = $urandom;
        return i;
    endfunction

    function automatic ins_t rnd();
        ins_t i;
        i = '0;
        i.valid       = ($urandom_range(0, 7) != 0);
        i.alu_op      = 3'($urandom);
        i.reg_dst     = 1'($urandom);
        i.branch_ctrl = 1'($urandom);
        i.mem_read    = 1'($urandom);
        i.mem_to_reg  = 1'($urandom);
        i.mem_write   = 1'($urandom);
        i.alu_src     = 1'($urandom);
        i.reg_write   = 1'($urandom);
        i.bne         = 1'($urandom);
        i.bgtz        = 1'($urandom);
        i.pc4         = $urandom;
        i.rs_data     = $urandom;
        i.rt_data     = $urandom;
        i.imm         = $urandom;
        i.rs = 5'($urandom_range(0, 7));
        i.rt = 5'($urandom_range(0, 7));
        i.rd = 5'($urandom);
        return i;
    endfunction

    initial begin
        logic st;
        n_chk = 0; n_pass = 0;
        mdl = '0; mdl_known = 1'b0;
        rst = 1'b1; hold = 1'b0; flush = 1'b0;
        cur = rnd();
        @(posedge clk); #1;

        // reset
        cycle(1, 0, 0, st);
        cur = rnd();
        cycle(1, 0, 0, st);
        chk("rst_valid", ex_valid, 1'b0);
        chk("rst_rd", ex_rd, 5'd0);
        cur = rnd(); cur.valid = 1'b1;
        #4;
        chk("rst_pc_we", pc_write_en, 1'b1);
        #2;

        // plain add
        cur = mk(1, 3'b010, 0, 1, 5'd1, 5'd2, 5'd3);
        cycle(0, 0, 0, st);
        chk("add_stall", st, 1'b0);
        chk("add_rd", ex_rd, 5'd3);
        chk("add_wr", ex_reg_write, 1'b1);
        chk("add_valid", ex_valid, 1'b1);

        // load-use: one bubble, then consumer loads
        cur = mk(1, 3'b010, 1, 1, 5'd1, 5'd5, 5'd0);
        cycle(0, 0, 0, st);
        cur = mk(1, 3'b010, 0, 1, 5'd5, 5'd6, 5'd7);
        cycle(0, 0, 0, st);
        chk("lu_stall", st, 1'b1);
        chk("lu_bubble", ex_valid, 1'b0);
        cycle(0, 0, 0, st);
        chk("lu_clear", st, 1'b0);
        chk("lu_rd", ex_rd, 5'd7);

        // $zero load and non-load producer
        cur = mk(1, 3'b010, 1, 1, 5'd1, 5'd0, 5'd0);
        cycle(0, 0, 0, st);
        cur = mk(1, 3'b010, 0, 1, 5'd0, 5'd4, 5'd8);
        cycle(0, 0, 0, st);
        chk("zero_nostall", st, 1'b0);
        cur = mk(1, 3'b010, 0, 1, 5'd1, 5'd5, 5'd9);
        cycle(0, 0, 0, st);
        cur = mk(1, 3'b010, 0, 1, 5'd5, 5'd2, 5'd10);
        cycle(0, 0, 0, st);
        chk("add_nostall", st, 1'b0);

        // flush wins over stall
        cur = mk(1, 3'b010, 1, 1, 5'd2, 5'd5, 5'd0);
        cycle(0, 0, 0, st);
        cur = mk(1, 3'b010, 0, 1, 5'd5, 5'd1, 5'd11);
        cycle(0, 0, 1, st);
        chk("fl_stall", st, 1'b1);
        chk("fl_bubble", obs, 156'd0);
        cycle(0, 0, 0, st);
        chk("fl_after", st, 1'b0);

        // hold across pending load-use
        cur = mk(1, 3'b010, 1, 1, 5'd2, 5'd5, 5'd0);
        cycle(0, 0, 0, st);
        cur = mk(1, 3'b010, 0, 1, 5'd3, 5'd5, 5'd12);
        for (int k = 0; k < 3; k++) begin
            cycle(0, 1, 0, st);
            chk("hold_stall", st, 1'b1);
            chk("hold_rt", ex_rt, 5'd5);
        end
        cycle(0, 0, 0, st);
        chk("hold_release", ex_valid, 1'b0);
        cycle(0, 0, 0, st);
        chk("hold_done", ex_rd, 5'd12);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            cur = rnd();
            cycle($urandom_range(0, 39) == 0,
                  $urandom_range(0, 5) == 0,
                  $urandom_range(0, 7) == 0, st);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
